mem_stage: RTL

//  Memory-access pipeline stage, directly downstream of the execute stage.

---
 rtl/mem_stage.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage sitting directly after EX.
// Latches the EX->MEM bus and captures the synchronous data-SRAM read word
// (the request was issued in EX, so the word is only valid during the first
// cycle an instruction sits here). The word is buffered when WB stalls.
// Loads are aligned and sign/zero extended, and the result goes to WB and to ID.
// Optional feature: define MEM_ALIGN_CHK_EN to flag misaligned ld.w/ld.h/ld.hu
// with ale=1. When ale is set, the register write and the ID bypass are suppressed.
module mem_stage #(
  parameter int EM_W  = 190,
  parameter int MW_W  = 185,
  parameter int FWD_W = 38
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ex_mem_valid,
  input  logic [EM_W-1:0]   ex_mem_bus,
  output logic              mem_allowin,
  output logic              mem_wb_valid,
  input  logic              wb_allowin,
  output logic [MW_W-1:0]   mem_wb_bus,
  input  logic [31:0]       data_sram_rdata,
  input  logic              wb_ex,
  input  logic              ertn_flush,
  output logic [FWD_W-1:0]  mem_id_bus
);

  // Extract the addressed byte or half-word and extend it. mem_type[2]
  // selects zero extension. Unknown encodings return the full word.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  mem_type,
                                              input logic [1:0]  addr_low2);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    byte_v = 8'h00;
    half_v = 16'h0000;
    res_v  = word;
    case (addr_low2)
      2'b00:   byte_v = word[7:0];
      2'b01:   byte_v = word[15:8];
      2'b10:   byte_v = word[23:16];
      2'b11:   byte_v = word[31:24];
      default: byte_v = 8'h00;
    endcase
    half_v = addr_low2[1] ? word[31:16] : word[15:0];
    case (mem_type[1:0])
      2'b01:   res_v = mem_type[2] ? {24'h000000, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b10:   res_v = mem_type[2] ? {16'h0000, half_v}   : {{16{half_v[15]}}, half_v};
      default: res_v = word;
    endcase
    return res_v;
  endfunction

  logic              mem_valid_r;
  logic [EM_W-1:0]   payload_r;
  logic [31:0]       rdata_buf_r;
  logic              buf_vld_r;
  logic              first_cyc_r;

  logic              flush_s;
  logic              mem_ready_go_s;
  logic              allowin_s;
  logic              load_in_s;
  logic              handoff_s;
  logic [31:0]       eff_rdata_s;
  logic [31:0]       load_data_s;
  logic [31:0]       final_result_s;
  logic              ale_s;
  logic              wb_gr_we_s;
  logic              bypass_s;

  // Payload field decode (MSB first)
  logic              gr_we_s;
  logic              res_from_mem_s;
  logic [2:0]        mem_type_s;
  logic [1:0]        addr_low2_s;
  logic [4:0]        dest_s;
  logic [31:0]       pc_s;
  logic [31:0]       inst_s;
  logic [31:0]       result_s;
  logic              csr_we_s;
  logic              csr_re_s;
  logic [13:0]       csr_num_s;
  logic [31:0]       csr_wmask_s;
  logic [31:0]       csr_wvalue_s;
  logic              ertn_s;
  logic              syscall_s;

  assign gr_we_s        = payload_r[189];
  assign res_from_mem_s = payload_r[188];
  assign mem_type_s     = payload_r[187:185];
  assign addr_low2_s    = payload_r[184:183];
  assign dest_s         = payload_r[182:178];
  assign pc_s           = payload_r[177:146];
  assign inst_s         = payload_r[145:114];
  assign result_s       = payload_r[113:82];
  assign csr_we_s       = payload_r[81];
  assign csr_re_s       = payload_r[80];
  assign csr_num_s      = payload_r[79:66];
  assign csr_wmask_s    = payload_r[65:34];
  assign csr_wvalue_s   = payload_r[33:2];
  assign ertn_s         = payload_r[1];
  assign syscall_s      = payload_r[0];

  // Read data is always available, so MEM never adds a stall of its own.
  assign mem_ready_go_s = 1'b1;
  assign flush_s        = wb_ex | ertn_flush;
  assign allowin_s      = ~mem_valid_r | (mem_ready_go_s & wb_allowin);
  assign load_in_s      = ex_mem_valid & allowin_s;
  assign handoff_s      = mem_valid_r & mem_ready_go_s & wb_allowin;
  assign eff_rdata_s    = buf_vld_r ? rdata_buf_r : data_sram_rdata;

`ifdef MEM_ALIGN_CHK_EN
  assign ale_s = res_from_mem_s &
                 (((mem_type_s[1:0] == 2'b10) & addr_low2_s[0]) |
                  ((mem_type_s == 3'b000) & (addr_low2_s != 2'b00)));
`else
  assign ale_s = 1'b0;
`endif

  // Stage valid bit: a flush overrides any incoming instruction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        mem_valid_r <= 1'b0;
    else if (flush_s)   mem_valid_r <= 1'b0;
    else if (allowin_s) mem_valid_r <= ex_mem_valid;
    else                mem_valid_r <= mem_valid_r;
  end

  // Payload register: it captures EX only on an actual transfer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        payload_r <= {EM_W{1'b0}};
    else if (load_in_s) payload_r <= ex_mem_bus;
    else                payload_r <= payload_r;
  end

  // First-cycle marker: the SRAM word is valid only in this cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      first_cyc_r <= 1'b0;
    else if (flush_s) first_cyc_r <= 1'b0;
    else              first_cyc_r <= load_in_s;
  end

  // Read-data buffer: hold the SRAM word when WB stalls in the first cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_buf_r <= 32'h0000_0000;
      buf_vld_r   <= 1'b0;
    end else if (flush_s || handoff_s) begin
      rdata_buf_r <= rdata_buf_r;
      buf_vld_r   <= 1'b0;
    end else if (first_cyc_r && mem_valid_r && !wb_allowin) begin
      rdata_buf_r <= data_sram_rdata;
      buf_vld_r   <= 1'b1;
    end else begin
      rdata_buf_r <= rdata_buf_r;
      buf_vld_r   <= buf_vld_r;
    end
  end

  // Result select: extended load data, or the EX result passed through.
  always_comb begin
    load_data_s    = load_extend(eff_rdata_s, mem_type_s, addr_low2_s);
    final_result_s = result_s;
    if (res_from_mem_s && !ale_s) final_result_s = load_data_s;
    else                          final_result_s = result_s;
  end

  // Output assembly toward WB and the ID bypass network.
  always_comb begin
    wb_gr_we_s   = gr_we_s & ~ale_s;
    bypass_s     = mem_valid_r & wb_gr_we_s;
    mem_allowin  = allowin_s;
    mem_wb_valid = mem_valid_r & mem_ready_go_s;
    mem_wb_bus   = {wb_gr_we_s, dest_s, pc_s, inst_s, final_result_s,
                    csr_we_s, csr_re_s, csr_num_s, csr_wmask_s, csr_wvalue_s,
                    ertn_s, syscall_s, ale_s};
    mem_id_bus   = {bypass_s, dest_s, final_result_s};
  end

endmodule
